// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor, DIFF = A - B computed one bit per clock,
// LSB first, through a single full-subtractor cell and a borrow flop.
// A start/busy/done handshake lets the control unit issue a subtract and wait.
// Optional macro SERIAL_SUB_OVF_EN adds a signed-overflow output OVF.
module serial_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] DIFF,
    output logic             BORROW
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic             borrow_q;
    logic [CW-1:0]    cnt;
    logic             load;
    logic             last_bit;
    logic             bit_a;
    logic             bit_b;
    logic             bit_d;
    logic             bit_bout;

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb;
    logic b_msb;
`endif

    // Full-subtractor cell working on the current LSBs of the operand registers
    always_comb begin
        bit_a    = a_sh[0];
        bit_b    = b_sh[0];
        bit_d    = bit_a ^ bit_b ^ borrow_q;
        bit_bout = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow_q);
        res_next = {bit_d, res[WIDTH-1:1]};
        last_bit = (cnt == LAST);
    end

    // State register; reset returns to IDLE and aborts any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; a start seen in DONE chains the next operation
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand/result shifting; DIFF and BORROW change only when the last bit is produced
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res      <= '0;
            borrow_q <= 1'b0;
            cnt      <= '0;
            DIFF     <= '0;
            BORROW   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            OVF      <= 1'b0;
`endif
        end else if (load) begin
            a_sh     <= A;
            b_sh     <= B;
            res      <= '0;
            borrow_q <= 1'b0;
            cnt      <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb    <= A[WIDTH-1];
            b_msb    <= B[WIDTH-1];
`endif
        end else if (state == RUN) begin
            a_sh     <= a_sh >> 1;
            b_sh     <= b_sh >> 1;
            res      <= res_next;
            borrow_q <= bit_bout;
            cnt      <= cnt + CW'(1);
            if (last_bit) begin
                DIFF   <= res_next;
                BORROW <= bit_bout;
`ifdef SERIAL_SUB_OVF_EN
                OVF    <= (a_msb != b_msb) && (bit_d != a_msb);
`endif
            end
        end
    end

endmodule
